// File: rtl/v_issue_pkg.sv
// Shared types for the vector issue queue: the buffered entry layout,
// the issue FSM encoding and the vl clamp helper.
package v_issue_pkg;

  localparam int VLMAX_DEFAULT = 256;

  typedef struct packed {
    logic        is_vset;
    logic [31:0] avl;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [4:0]  vd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  uimm5;
    logic [3:0]  funct;
    logic [1:0]  permute;
    logic [1:0]  alusrc;
    logic [1:0]  mode_lsu;
    logic        mask_en;
    logic        dmr;
    logic        dmw;
    logic        reg_we;
    logic        mem_reg;
    logic        xout;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  // Full 32-bit unsigned compare before truncating to the 9-bit vl.
  function automatic logic [8:0] clamp_vl(input logic [31:0] avl, input int vlmax);
    return (avl > 32'(vlmax)) ? 9'(vlmax) : avl[8:0];
  endfunction

endpackage

// File: rtl/v_issue_fifo.sv
// Generic synchronous FIFO with wrapping pointers, an occupancy count
// and a synchronous flush that empties it in one edge.
module v_issue_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count decide what is visible.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/v_issue_queue.sv
// Vector issue queue: buffers decoded vector entries, applies vset commands
// to vl locally and issues operations one at a time with a rolling id.
module v_issue_queue
  import v_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int VLMAX = VLMAX_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_vset,
  input  logic [31:0] in_avl,
  input  logic [4:0]  in_vs1,
  input  logic [4:0]  in_vs2,
  input  logic [4:0]  in_vd,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [4:0]  in_uimm5,
  input  logic [3:0]  in_funct,
  input  logic [1:0]  in_permute,
  input  logic [1:0]  in_alusrc,
  input  logic [1:0]  in_mode_lsu,
  input  logic        in_mask_en,
  input  logic        in_dmr,
  input  logic        in_dmw,
  input  logic        in_reg_we,
  input  logic        in_mem_reg,
  input  logic        in_xout,
  output logic        vset_valid,
  output logic [8:0]  vset_vl,
  output logic        idle,
  output logic [8:0]  vl,
  output logic        I_clear,
  output logic [2:0]  I_id,
  output logic        I_start,
  output logic [4:0]  I_vs1,
  output logic [4:0]  I_vs2,
  output logic [4:0]  I_vd,
  output logic [31:0] I_rs1,
  output logic [31:0] I_rs2,
  output logic [4:0]  I_uimm5,
  output logic [3:0]  I_funct,
  output logic [1:0]  I_permute,
  output logic [1:0]  I_alusrc,
  output logic [1:0]  I_mode_lsu,
  output logic        I_mask_en,
  output logic        I_dmr,
  output logic        I_dmw,
  output logic        I_reg_we,
  output logic        I_mem_reg,
  output logic        I_xout,
  input  logic        v_stall,
  input  logic        v_done
);

  state_t                  state;
  entry_t                  in_entry;
  entry_t                  head;
  logic [$bits(entry_t)-1:0] head_bits;
  logic                    full;
  logic                    empty;
  logic                    pop;
  logic [8:0]              new_vl;

  assign in_entry = '{is_vset: in_is_vset, avl: in_avl, vs1: in_vs1, vs2: in_vs2,
                      vd: in_vd, rs1: in_rs1, rs2: in_rs2, uimm5: in_uimm5,
                      funct: in_funct, permute: in_permute, alusrc: in_alusrc,
                      mode_lsu: in_mode_lsu, mask_en: in_mask_en, dmr: in_dmr,
                      dmw: in_dmw, reg_we: in_reg_we, mem_reg: in_mem_reg,
                      xout: in_xout};

  assign in_ready = !full && !flush;
  assign idle     = empty && (state == S_IDLE);
  assign pop      = (state == S_IDLE) && !empty && !flush;
  assign head     = entry_t'(head_bits);
  assign new_vl   = clamp_vl(head.avl, VLMAX);

  v_issue_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .din   (in_entry),
    .dout  (head_bits),
    .full  (full),
    .empty (empty)
  );

  // vset entries drain only from IDLE, so vl is frozen while an operation is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      vl         <= '0;
      vset_valid <= 1'b0;
      vset_vl    <= '0;
      I_clear    <= 1'b0;
      I_id       <= '0;
      I_start    <= 1'b0;
      I_vs1      <= '0;
      I_vs2      <= '0;
      I_vd       <= '0;
      I_rs1      <= '0;
      I_rs2      <= '0;
      I_uimm5    <= '0;
      I_funct    <= '0;
      I_permute  <= '0;
      I_alusrc   <= '0;
      I_mode_lsu <= '0;
      I_mask_en  <= 1'b0;
      I_dmr      <= 1'b0;
      I_dmw      <= 1'b0;
      I_reg_we   <= 1'b0;
      I_mem_reg  <= 1'b0;
      I_xout     <= 1'b0;
    end else if (flush) begin
      state      <= S_IDLE;
      I_start    <= 1'b0;
      I_id       <= '0;
      I_clear    <= 1'b1;
      vset_valid <= 1'b0;
    end else begin
      I_clear    <= 1'b0;
      vset_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            if (head.is_vset) begin
              vl         <= new_vl;
              vset_vl    <= new_vl;
              vset_valid <= 1'b1;
            end else begin
              I_vs1      <= head.vs1;
              I_vs2      <= head.vs2;
              I_vd       <= head.vd;
              I_rs1      <= head.rs1;
              I_rs2      <= head.rs2;
              I_uimm5    <= head.uimm5;
              I_funct    <= head.funct;
              I_permute  <= head.permute;
              I_alusrc   <= head.alusrc;
              I_mode_lsu <= head.mode_lsu;
              I_mask_en  <= head.mask_en;
              I_dmr      <= head.dmr;
              I_dmw      <= head.dmw;
              I_reg_we   <= head.reg_we;
              I_mem_reg  <= head.mem_reg;
              I_xout     <= head.xout;
              I_start    <= 1'b1;
              state      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (!v_stall) begin
            I_start <= 1'b0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (v_done) begin
            I_id  <= I_id + 3'd1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_v_issue_queue.sv
// Bench for v_issue_queue: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of entries, vl and the op id.
module tb_v_issue_queue;
  import v_issue_pkg::*;

  localparam int DEPTH = 4;
  localparam int VLMAX = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_vset = 1'b0;
  logic [31:0] in_avl = '0;
  logic [4:0]  in_vs1 = '0, in_vs2 = '0, in_vd = '0, in_uimm5 = '0;
  logic [31:0] in_rs1 = '0, in_rs2 = '0;
  logic [3:0]  in_funct = '0;
  logic [1:0]  in_permute = '0, in_alusrc = '0, in_mode_lsu = '0;
  logic        in_mask_en = 0, in_dmr = 0, in_dmw = 0, in_reg_we = 0, in_mem_reg = 0, in_xout = 0;
  logic        vset_valid, idle, I_clear, I_start;
  logic [8:0]  vset_vl, vl;
  logic [2:0]  I_id;
  logic [4:0]  I_vs1, I_vs2, I_vd, I_uimm5;
  logic [31:0] I_rs1, I_rs2;
  logic [3:0]  I_funct;
  logic [1:0]  I_permute, I_alusrc, I_mode_lsu;
  logic        I_mask_en, I_dmr, I_dmw, I_reg_we, I_mem_reg, I_xout;
  logic        v_stall = 1'b0;
  logic        v_done = 1'b0;

  v_issue_queue #(.DEPTH(DEPTH), .VLMAX(VLMAX)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_vset(in_is_vset), .in_avl(in_avl), .in_vs1(in_vs1), .in_vs2(in_vs2),
    .in_vd(in_vd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_uimm5(in_uimm5),
    .in_funct(in_funct), .in_permute(in_permute), .in_alusrc(in_alusrc),
    .in_mode_lsu(in_mode_lsu), .in_mask_en(in_mask_en), .in_dmr(in_dmr), .in_dmw(in_dmw),
    .in_reg_we(in_reg_we), .in_mem_reg(in_mem_reg), .in_xout(in_xout),
    .vset_valid(vset_valid), .vset_vl(vset_vl), .idle(idle), .vl(vl),
    .I_clear(I_clear), .I_id(I_id), .I_start(I_start), .I_vs1(I_vs1), .I_vs2(I_vs2),
    .I_vd(I_vd), .I_rs1(I_rs1), .I_rs2(I_rs2), .I_uimm5(I_uimm5), .I_funct(I_funct),
    .I_permute(I_permute), .I_alusrc(I_alusrc), .I_mode_lsu(I_mode_lsu),
    .I_mask_en(I_mask_en), .I_dmr(I_dmr), .I_dmw(I_dmw), .I_reg_we(I_reg_we),
    .I_mem_reg(I_mem_reg), .I_xout(I_xout), .v_stall(v_stall), .v_done(v_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending entries in arrival order, architectural vl,
  // next op id, and the vector unit's view (0 none, 1 offered, 2 running).
  entry_t     q[$];
  entry_t     cur, drv;
  logic [8:0] m_vl = '0;
  logic [2:0] m_id = '0;
  int vu_state = 0, done_cnt = 0, stall_left = 0, start_cycles = 0;
  int stall_init = 0, stall_pct = 0, noise_pct = 0, done_min = 1, done_max = 1;
  bit exp_clear = 0, exp_vset = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ref_vl(input logic [31:0] avl);
    return (avl > 32'(VLMAX)) ? 9'(VLMAX) : avl[8:0];
  endfunction

  function automatic logic [127:0] exp_fields(input entry_t e);
    return 128'({e.vs1, e.vs2, e.vd, e.rs1, e.rs2, e.uimm5, e.funct, e.permute, e.alusrc,
                 e.mode_lsu, e.mask_en, e.dmr, e.dmw, e.reg_we, e.mem_reg, e.xout});
  endfunction

  function automatic logic [127:0] obs_fields();
    return 128'({I_vs1, I_vs2, I_vd, I_rs1, I_rs2, I_uimm5, I_funct, I_permute, I_alusrc,
                 I_mode_lsu, I_mask_en, I_dmr, I_dmw, I_reg_we, I_mem_reg, I_xout});
  endfunction

  function automatic entry_t rand_entry(input bit is_vset);
    entry_t e;
    e          = '0;
    e.is_vset  = is_vset;
    e.avl      = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 300));
    e.vs1      = 5'($urandom);
    e.vs2      = 5'($urandom);
    e.vd       = 5'($urandom);
    e.rs1      = 32'($urandom);
    e.rs2      = 32'($urandom);
    e.uimm5    = 5'($urandom);
    e.funct    = 4'($urandom);
    e.permute  = 2'($urandom);
    e.alusrc   = 2'($urandom);
    e.mode_lsu = 2'($urandom);
    {e.mask_en, e.dmr, e.dmw, e.reg_we, e.mem_reg, e.xout} = 6'($urandom);
    return e;
  endfunction

  task automatic drive(input entry_t e, input bit v);
    drv = e;
    in_valid = v;
    in_is_vset = e.is_vset;  in_avl = e.avl;
    in_vs1 = e.vs1;  in_vs2 = e.vs2;  in_vd = e.vd;  in_rs1 = e.rs1;  in_rs2 = e.rs2;
    in_uimm5 = e.uimm5;  in_funct = e.funct;  in_permute = e.permute;
    in_alusrc = e.alusrc;  in_mode_lsu = e.mode_lsu;  in_mask_en = e.mask_en;
    in_dmr = e.dmr;  in_dmw = e.dmw;  in_reg_we = e.reg_we;  in_mem_reg = e.mem_reg;
    in_xout = e.xout;
  endtask

  // One clock: check combinational outputs before the edge, advance the model
  // at the edge, check registered outputs after it, then play the vector unit.
  task automatic cycle();
    bit     pushed, s_flush, s_stall, s_done;
    int     pre;
    entry_t pe, e;
    @(negedge clk);
    check("in_ready", in_ready, !flush && (q.size() < DEPTH));
    check("idle", idle, (q.size() == 0) && (vu_state == 0));
    pushed  = in_valid && !flush && (q.size() < DEPTH);
    pe      = drv;
    s_flush = flush;
    s_stall = v_stall;
    s_done  = v_done;
    @(posedge clk);
    exp_vset = 0;
    if (s_flush) begin
      q.delete();
      m_id      = '0;
      vu_state  = 0;
      exp_clear = 1;
    end else begin
      exp_clear = 0;
      pre = vu_state;
      if (pre == 1 && !s_stall) begin
        vu_state = 2;
        done_cnt = $urandom_range(done_min, done_max);
      end else if (pre == 2 && s_done) begin
        m_id     = m_id + 3'd1;
        vu_state = 0;
      end
      if (pre == 0 && q.size() > 0) begin
        e = q.pop_front();
        if (e.is_vset) begin
          m_vl     = ref_vl(e.avl);
          exp_vset = 1;
        end else begin
          cur          = e;
          vu_state     = 1;
          stall_left   = stall_init;
          start_cycles = 0;
        end
      end
      if (pushed) q.push_back(pe);
    end
    #1;
    check("I_clear", I_clear, exp_clear);
    check("vset_valid", vset_valid, exp_vset);
    if (exp_vset) check("vset_vl", vset_vl, m_vl);
    check("vl", vl, m_vl);
    check("I_id", I_id, m_id);
    check("I_start", I_start, vu_state == 1);
    if (vu_state == 1) check("fields", obs_fields(), exp_fields(cur));
    if (I_start) start_cycles++;
    if (vu_state == 1) begin
      if (stall_left > 0) begin
        v_stall = 1'b1;
        stall_left--;
      end else begin
        v_stall = ($urandom_range(0, 99) < stall_pct);
      end
    end else begin
      v_stall = ($urandom_range(0, 99) < noise_pct);
    end
    if (vu_state == 2) begin
      done_cnt--;
      v_done = (done_cnt == 0);
    end else begin
      v_done = ($urandom_range(0, 99) < noise_pct);
    end
  endtask

  task automatic push_one(input entry_t e);
    drive(e, 1'b1);
    cycle();
    drive(e, 1'b0);
  endtask

  task automatic wait_quiet(input int max_cycles);
    for (int i = 0; i < max_cycles && !(q.size() == 0 && vu_state == 0); i++) cycle();
    check("quiet_idle", idle, 1'b1);
  endtask

  task automatic model_reset();
    q.delete();
    m_vl = '0;  m_id = '0;  vu_state = 0;  exp_clear = 0;  exp_vset = 0;
    v_stall = 1'b0;  v_done = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    entry_t e;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vl", vl, 9'd0);
    check("rst_vset_valid", vset_valid, 1'b0);
    check("rst_vset_vl", vset_vl, 9'd0);
    check("rst_I_start", I_start, 1'b0);
    check("rst_I_id", I_id, 3'd0);
    check("rst_I_clear", I_clear, 1'b0);
    check("rst_fields", obs_fields(), 128'd0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_idle", idle, 1'b1);
    reset = 1'b0;
    model_reset();

    // vset clamping above VLMAX, then a small request.
    e = rand_entry(1'b1);  e.avl = 32'd300;
    push_one(e);
    cycle();
    check("vset300_valid", vset_valid, 1'b1);
    check("vset300_vl", vset_vl, 9'd256);
    check("vl_256", vl, 9'd256);
    e.avl = 32'd17;
    push_one(e);
    cycle();
    check("vl_17", vl, 9'd17);

    // Single operation, no stall, done five cycles after acceptance.
    done_min = 5;  done_max = 5;
    e = rand_entry(1'b0);  e.vd = 5'd3;  e.funct = 4'h2;
    push_one(e);
    cycle();
    check("op1_start", I_start, 1'b1);
    check("op1_vd", I_vd, 5'd3);
    check("op1_funct", I_funct, 4'h2);
    check("op1_id", I_id, 3'd0);
    wait_quiet(50);
    check("op1_start_len", start_cycles, 1);
    check("op1_id_after", I_id, 3'd1);
    check("op1_idle", idle, 1'b1);

    // Three stall cycles keep the start offered for four cycles.
    stall_init = 3;
    push_one(rand_entry(1'b0));
    wait_quiet(50);
    check("stall_start_len", start_cycles, 4);
    stall_init = 0;

    // Fill the queue behind a long operation; the fifth push is refused.
    done_min = 8;  done_max = 8;
    push_one(rand_entry(1'b0));
    cycle();
    for (int i = 0; i < 5; i++) begin
      drive(rand_entry(1'b0), 1'b1);
      cycle();
    end
    in_valid = 1'b0;
    check("full_ready", in_ready, 1'b0);
    done_min = 1;  done_max = 3;
    wait_quiet(200);

    // op, vset(8), op: vl changes only between the two operations.
    done_min = 3;  done_max = 3;
    push_one(rand_entry(1'b0));
    e = rand_entry(1'b1);  e.avl = 32'd8;
    push_one(e);
    push_one(rand_entry(1'b0));
    wait_quiet(100);
    check("vl_8", vl, 9'd8);

    // Flush during WAIT with two queued entries and a concurrent push.
    done_min = 30;  done_max = 30;
    push_one(rand_entry(1'b0));
    cycle();
    push_one(rand_entry(1'b0));
    push_one(rand_entry(1'b0));
    e = rand_entry(1'b0);
    drive(e, 1'b1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(e, 1'b0);
    check("flush_clear", I_clear, 1'b1);
    check("flush_idle", idle, 1'b1);
    check("flush_id", I_id, 3'd0);
    check("flush_vl", vl, 9'd8);
    repeat (20) cycle();

    // Random traffic with stalls, spurious done pulses and rare flushes.
    stall_pct = 30;  noise_pct = 10;  done_min = 1;  done_max = 4;
    for (int i = 0; i < 3000; i++) begin
      drive(rand_entry($urandom_range(0, 99) < 25), $urandom_range(0, 99) < 60);
      flush = ($urandom_range(0, 199) == 0);
      cycle();
    end
    flush = 1'b0;  in_valid = 1'b0;  stall_pct = 0;  noise_pct = 0;
    wait_quiet(300);

    // Reset in the middle of an operation with work still queued.
    done_min = 20;  done_max = 20;
    push_one(rand_entry(1'b0));
    cycle();
    push_one(rand_entry(1'b0));
    reset = 1'b1;
    #1;
    model_reset();
    check("mid_rst_vl", vl, 9'd0);
    check("mid_rst_start", I_start, 1'b0);
    check("mid_rst_id", I_id, 3'd0);
    check("mid_rst_clear", I_clear, 1'b0);
    check("mid_rst_idle", idle, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    done_min = 2;  done_max = 2;
    e = rand_entry(1'b1);  e.avl = 32'd5;
    push_one(e);
    push_one(rand_entry(1'b0));
    wait_quiet(50);
    check("post_rst_vl", vl, 9'd5);
    check("post_rst_id", I_id, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/v_issue_queue.md
# v_issue_queue

Vector issue queue between the scalar core's decode stage and the vector execution unit. Buffers decoded vector instructions in a small FIFO and executes `vsetvl`-type commands locally to maintain the `vl` register. Issues one vector operation at a time with a start/stall/done handshake and tags each operation with a rolling 3-bit id. Lets the scalar pipeline keep running while long vector operations are in flight.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; must be a power of 2, minimum 2.
- `VLMAX`, 256: maximum vector length; must fit in 9 bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `flush` in 1: synchronous; discards all queued and in-flight work.
- `in_valid` in 1: the core offers an entry.
- `in_ready` out 1: the queue accepts an entry (`!full && !flush`).
- `in_is_vset` in 1: 1 means the entry is a vset command; 0 means it is a vector operation.
- `in_avl` in 32: requested application vector length (vset entries only).
- `in_vs1`, `in_vs2`, `in_vd` in 5 each: register specifiers.
- `in_rs1`, `in_rs2` in 32 each: scalar operands.
- `in_uimm5` in 5: immediate.
- `in_funct` in 4, `in_permute` in 2, `in_alusrc` in 2, `in_mode_lsu` in 2: control fields.
- `in_mask_en`, `in_dmr`, `in_dmw`, `in_reg_we`, `in_mem_reg`, `in_xout` in 1 each: control bits.
- `vset_valid` out 1: one-cycle pulse when a vset command completes.
- `vset_vl` out 9: new `vl` value, for scalar `rd` writeback; valid with `vset_valid`.
- `idle` out 1: FIFO empty and FSM in IDLE (used for fences).
- `vl` out 9: current vector length register.
- `I_clear` out 1: one-cycle pulse after a flush.
- `I_id` out 3: id of the operation currently issued.
- `I_start` out 1: start request.
- `I_vs1` … `I_mode_lsu` out: registered copies of the issued entry's fields, same widths as the `in_*` fields.
- `v_stall` in 1: the vector unit cannot accept a start this cycle.
- `v_done` in 1: one-cycle pulse when the current operation completes.

## Operation
- The FIFO has `DEPTH` entries with wrapping read and write pointers plus a count.
- Push occurs when `in_valid && in_ready`. A full FIFO holds `in_ready` low; there is no same-cycle bypass when full.
- FSM states are IDLE, ISSUE and WAIT.
- IDLE, head is a vset entry:
  - `vl <= (in_avl > VLMAX) ? VLMAX : in_avl[8:0]`, with a full 32-bit unsigned compare.
  - Pop the entry, pulse `vset_valid` with `vset_vl` equal to the new `vl`, stay in IDLE.
- IDLE, head is an operation: pop it, latch all fields onto the `I_*` outputs, set `I_start=1`, go to ISSUE.
- ISSUE: hold `I_start` and the fields while `v_stall=1`. In the first cycle with `v_stall=0` the start is accepted; deassert `I_start` next cycle and go to WAIT.
- WAIT: on `v_done=1`, increment `I_id` (mod 8) and go to IDLE.
  - The vector unit never raises `v_done` earlier than the cycle after start acceptance.
  - `v_done` in IDLE or ISSUE is ignored.
- A vset entry waits behind any in-flight operation, so `vl` never changes during an operation.
- Flush:
  - Next edge: FIFO emptied, FSM to IDLE, `I_start=0`, `I_id=0`, `I_clear=1` for one cycle.
  - `vl` is retained.
  - A push in the flush cycle is dropped (`in_ready=0`).
  - Flush takes priority over every other event in the same cycle.
- Reset mid-operation: same effect as flush, except `vl=0` and `I_clear=0`.

## Timing
- Reset values:
  - All `I_*` outputs, `vl`, `vset_valid`, `vset_vl`, `I_clear` and `I_id` are 0.
  - `in_ready=1`, `idle=1`.
- All outputs are registered except `in_ready` and `idle`, which are combinational from state and count.
- Push at edge N into an empty, idle queue:
  - Operation: `I_start=1` after edge N+1.
  - vset: `vset_valid` and the new `vl` after edge N+1.
- Back-to-back operations: `v_done` at edge M gives IDLE after M, and the next `I_start` after M+1. There is a minimum of one idle cycle between operations.
- Simultaneous push and pop in one cycle is allowed when not full; the count is unchanged.
- Pointer wrap from `DEPTH-1` to 0 is silent.

## Structure
- Package `v_issue_pkg` holds:
  - the packed entry type (all `in_*` fields plus `is_vset` and `avl`);
  - the FSM state encoding;
  - `VLMAX_DEFAULT`.
- Sub-module `v_issue_fifo` is a generic synchronous FIFO (`WIDTH`, `DEPTH`; push/pop/full/empty/flush). `v_issue_queue` instantiates it and contains the FSM, the `vl` register and the id counter.

## Test plan
- Reset, then push vset with `avl=300` → one cycle later `vset_valid=1`, `vset_vl=256`, `vl=256`. Then `avl=17` → `vl=17`.
- Push one operation (`vd=3`, `funct=4'h2`), `v_stall=0`, `v_done` 5 cycles after acceptance → `I_start` high exactly 1 cycle, `I_vd=3`, `I_id=0`. After `v_done`, `I_id=1` and `idle=1`.
- Hold `v_stall=1` for 3 cycles during ISSUE → `I_start` and the fields stable for 4 cycles, and WAIT is entered only after acceptance.
- Push 5 entries while the first operation is in WAIT with `DEPTH=4` → `in_ready=0` with 4 queued. Deliver 4 `v_done` pulses → all issued in order, `I_id` runs 1..4, and wrap of both the pointers and the id is checked across 10 operations.
- Sequence op, vset(`avl=8`), op → the vset is applied only after the first op's `v_done`, and the second op sees `vl=8`.
- Flush during WAIT with 2 entries queued plus a simultaneous push → one `I_clear` pulse, `idle=1` next cycle, `I_id=0`, `vl` unchanged, and none of the 2 queued entries nor the pushed entry is ever issued.
